// File: rtl/bound_flasher_monitor.sv
// bound_flasher_monitor: observes the bound-flasher LED bus, decodes the
// thermometer pattern into a lit-LED level, follows the three-ramp cycle,
// pulses on kickbacks and completed cycles, and keeps sticky error flags.
module bound_flasher_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      led_in,
  input  logic             led_valid,
  input  logic             clear_err,
  output logic [4:0]       level,
  output logic [2:0]       phase,
  output logic             kickback,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             therm_err,
  output logic             step_err,
  output logic             seq_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_A   = 3'd1,
    DN_A   = 3'd2,
    UP_B   = 3'd3,
    DN_B   = 3'd4,
    UP_C   = 3'd5,
    DN_C   = 3'd6,
    RESYNC = 3'd7
  } phase_t;

  phase_t           state_q, state_d;
  logic [4:0]       level_q, level_d, k;
  logic [CNT_W-1:0] cnt_q;
  logic             kick_q, done_q, therm_q, step_q, seq_q;
  logic             kick_d, done_d, therm_set, step_set, seq_set, cnt_inc;
  logic             therm_ok, up, down, hold, seq_bad;

  // Popcount of the bus; only meaningful when the pattern is a thermometer code
  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < 16; i++) k = k + 5'(led_in[i]);
  end

  // 2^k-1 has no bit in common with its successor
  assign therm_ok = (led_in & (led_in + 16'd1)) == '0;
  assign up       = (k == level_q + 5'd1);
  assign down     = (level_q != '0) && (k == level_q - 5'd1);
  assign hold     = (k == level_q);

  // Next-state, level, pulse and error-set decision for the current sample
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    kick_d    = 1'b0;
    done_d    = 1'b0;
    therm_set = 1'b0;
    step_set  = 1'b0;
    seq_set   = 1'b0;
    cnt_inc   = 1'b0;
    seq_bad   = 1'b0;
    if (led_valid) begin
      if (state_q == RESYNC) begin
        // Errors are muted here; only a legal level-0 sample re-arms tracking
        if (therm_ok) begin
          level_d = k;
          if (k == '0) state_d = IDLE;
        end
      end else if (!therm_ok) begin
        therm_set = 1'b1;
        state_d   = RESYNC;
      end else if (!(up || down || hold)) begin
        step_set = 1'b1;
        level_d  = k;
        state_d  = RESYNC;
      end else begin
        level_d = k;
        if (!hold) begin
          case (state_q)
            IDLE: begin
              if (up) state_d = UP_A;
              else    seq_bad = 1'b1;
            end
            UP_A: begin
              if (up && level_q < 5'd6)          state_d = UP_A;
              else if (down && level_q == 5'd6)  state_d = DN_A;
              else                               seq_bad = 1'b1;
            end
            DN_A: begin
              if (down)                          state_d = DN_A;
              else if (up && level_q == 5'd0)    state_d = UP_B;
              else                               seq_bad = 1'b1;
            end
            UP_B: begin
              if (up && level_q < 5'd11)         state_d = UP_B;
              else if (down && level_q == 5'd6) begin
                state_d = DN_A;
                kick_d  = 1'b1;
              end
              else if (down && level_q == 5'd11) state_d = DN_B;
              else                               seq_bad = 1'b1;
            end
            DN_B: begin
              if (down && level_q > 5'd5)        state_d = DN_B;
              else if (up && level_q == 5'd5)    state_d = UP_C;
              else if (down && level_q == 5'd5) begin
                state_d = DN_A;
                kick_d  = 1'b1;
              end
              else                               seq_bad = 1'b1;
            end
            UP_C: begin
              if (up && level_q < 5'd16)         state_d = UP_C;
              else if (down && level_q == 5'd16) state_d = DN_C;
              else if (down && (level_q == 5'd6 || level_q == 5'd11)) begin
                state_d = DN_B;
                kick_d  = 1'b1;
              end
              else                               seq_bad = 1'b1;
            end
            DN_C: begin
              if (down && level_q == 5'd1) begin
                state_d = IDLE;
                done_d  = 1'b1;
                cnt_inc = 1'b1;
              end
              else if (down)                     state_d = DN_C;
              else                               seq_bad = 1'b1;
            end
            default: seq_bad = 1'b0;
          endcase
          if (seq_bad) begin
            seq_set = 1'b1;
            state_d = RESYNC;
          end
        end
      end
    end
  end

  // State, level, pulses, saturating counter and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      kick_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      therm_q <= 1'b0;
      step_q  <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      kick_q  <= kick_d;
      done_q  <= done_d;
      if (cnt_inc && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      // A fresh error wins over a simultaneous clear
      therm_q <= (therm_q & ~clear_err) | therm_set;
      step_q  <= (step_q  & ~clear_err) | step_set;
      seq_q   <= (seq_q   & ~clear_err) | seq_set;
    end
  end

  assign level       = level_q;
  assign phase       = state_q;
  assign kickback    = kick_q;
  assign cycle_done  = done_q;
  assign cycle_count = cnt_q;
  assign therm_err   = therm_q;
  assign step_err    = step_q;
  assign seq_err     = seq_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Self-checking bench for bound_flasher_monitor: directed ramps plus a random
// walk, every cycle compared against a table-driven reference model.
module tb_bound_flasher_monitor;

  logic        clk;
  logic        rst_n;
  logic [15:0] led_in;
  logic        led_valid;
  logic        clear_err;
  logic [4:0]  level, level_2;
  logic [2:0]  phase, phase_2;
  logic        kickback, kickback_2, cycle_done, cycle_done_2;
  logic [7:0]  cycle_count;
  logic [1:0]  cycle_count_2;
  logic        therm_err, step_err, seq_err;
  logic        therm_err_2, step_err_2, seq_err_2;

  bound_flasher_monitor #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .led_valid(led_valid),
    .clear_err(clear_err), .level(level), .phase(phase), .kickback(kickback),
    .cycle_done(cycle_done), .cycle_count(cycle_count), .therm_err(therm_err),
    .step_err(step_err), .seq_err(seq_err)
  );

  bound_flasher_monitor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .led_valid(led_valid),
    .clear_err(clear_err), .level(level_2), .phase(phase_2), .kickback(kickback_2),
    .cycle_done(cycle_done_2), .cycle_count(cycle_count_2), .therm_err(therm_err_2),
    .step_err(step_err_2), .seq_err(seq_err_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Legal moves: phase, direction, range of previous level, next phase, event (1 kick, 2 done)
  typedef struct packed { int ph; int dir; int lo; int hi; int nx; int ev; } move_t;
  localparam move_t MOVES [17] = '{
    '{0,  1,  0,  0, 1, 0},
    '{1,  1,  0,  5, 1, 0}, '{1, -1,  6,  6, 2, 0},
    '{2, -1,  1, 16, 2, 0}, '{2,  1,  0,  0, 3, 0},
    '{3,  1,  0, 10, 3, 0}, '{3, -1,  6,  6, 2, 1}, '{3, -1, 11, 11, 4, 0},
    '{4, -1,  6, 16, 4, 0}, '{4,  1,  5,  5, 5, 0}, '{4, -1,  5,  5, 2, 1},
    '{5,  1,  0, 15, 5, 0}, '{5, -1, 16, 16, 6, 0}, '{5, -1,  6,  6, 4, 1},
    '{5, -1, 11, 11, 4, 1},
    '{6, -1,  2, 16, 6, 0}, '{6, -1,  1,  1, 0, 2}
  };

  int m_level, m_phase, m_cnt, m_cnt2;
  bit m_kick, m_done, m_therm, m_step, m_seq;

  task automatic model_step(input logic v, input logic [15:0] p, input logic clr, input logic rst);
    int kk, d, hit;
    bit legal, t, s, q;
    m_kick = 0;
    m_done = 0;
    if (!rst) begin
      m_level = 0; m_phase = 0; m_cnt = 0; m_cnt2 = 0;
      m_therm = 0; m_step = 0; m_seq = 0;
      return;
    end
    t = 0; s = 0; q = 0; legal = 0; kk = 0;
    if (v) begin
      for (int j = 0; j <= 16; j++)
        if (32'(p) == (32'd1 << j) - 32'd1) begin legal = 1; kk = j; end
      d = kk - m_level;
      if (m_phase == 7) begin
        if (legal) begin
          m_level = kk;
          if (kk == 0) m_phase = 0;
        end
      end else if (!legal) begin
        t = 1; m_phase = 7;
      end else if (d > 1 || d < -1) begin
        s = 1; m_level = kk; m_phase = 7;
      end else begin
        if (d != 0) begin
          hit = -1;
          foreach (MOVES[j])
            if (MOVES[j].ph == m_phase && MOVES[j].dir == d &&
                m_level >= MOVES[j].lo && m_level <= MOVES[j].hi) hit = j;
          if (hit < 0) begin
            q = 1; m_phase = 7;
          end else begin
            m_phase = MOVES[hit].nx;
            m_kick  = (MOVES[hit].ev == 1);
            m_done  = (MOVES[hit].ev == 2);
          end
        end
        m_level = kk;
      end
    end
    m_therm = (m_therm && !clr) || t;
    m_step  = (m_step  && !clr) || s;
    m_seq   = (m_seq   && !clr) || q;
    if (m_done) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  function automatic logic [15:0] pat(input int k);
    logic [16:0] t;
    t = (17'd1 << k) - 17'd1;
    return t[15:0];
  endfunction

  bit gate = 0;
  int kick_n = 0;
  int walk = 0;
  int last_ph = 0;

  task automatic drive(input logic v, input logic [15:0] p, input logic clr, input logic rst);
    logic [20:0] got, exp;
    @(negedge clk);
    led_valid = v; led_in = p; clear_err = clr; rst_n = rst;
    @(posedge clk);
    #1;
    model_step(v, p, clr, rst);
    got = {level, phase, kickback, cycle_done, cycle_count, therm_err, step_err, seq_err};
    exp = {5'(m_level), 3'(m_phase), m_kick, m_done, 8'(m_cnt), m_therm, m_step, m_seq};
    check("state", 32'(got), 32'(exp));
    check("cnt_sat", 32'(cycle_count_2), 32'(m_cnt2));
    if (kickback === 1'b1) kick_n++;
    if (32'(phase) != last_ph) begin
      walk = walk * 10 + 32'(phase);
      last_ph = 32'(phase);
    end
  endtask

  task automatic feed(input int k);
    if (gate) repeat ($urandom_range(0, 2)) drive(1'b0, 16'($urandom), 1'b0, 1'b1);
    drive(1'b1, pat(k), 1'b0, 1'b1);
    if (gate && $urandom_range(0, 1) == 1) drive(1'b1, pat(k), 1'b0, 1'b1);
  endtask

  task automatic ramp(input int a, input int b);
    if (a < b) for (int l = a + 1; l <= b; l++) feed(l);
    else       for (int l = a - 1; l >= b; l--) feed(l);
  endtask

  task automatic nominal();
    feed(0);
    ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
  endtask

  task automatic clear_flags();
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  initial begin
    int dir, nxt, r;
    bit clr;
    led_valid = 0; led_in = '0; clear_err = 0; rst_n = 0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("rst_level", 32'(level), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_count", 32'(cycle_count), 0);
    check("rst_flags", 32'({therm_err, step_err, seq_err, kickback, cycle_done}), 0);

    // Nominal cycle
    walk = 0; last_ph = 32'(phase); kick_n = 0;
    nominal();
    check("nom_walk", 32'(walk), 1234560);
    check("nom_done", 32'(cycle_done), 1);
    check("nom_count", 32'(cycle_count), 1);
    check("nom_kicks", 32'(kick_n), 0);
    check("nom_flags", 32'({therm_err, step_err, seq_err}), 0);

    // Kickback at 6 while climbing UP_B, then finish a cycle
    ramp(0, 6); ramp(6, 0); ramp(0, 6); feed(5);
    check("kb6_pulse", 32'(kickback), 1);
    check("kb6_phase", 32'(phase), 2);
    ramp(5, 0); ramp(0, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
    check("kb6_count", 32'(cycle_count), 2);

    // Late kickback from 11 detected at 5 -> 4
    ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 10);
    check("kb11_dnb", 32'(phase), 4);
    ramp(10, 5); feed(4);
    check("kb11_pulse", 32'(kickback), 1);
    check("kb11_phase", 32'(phase), 2);
    check("kb11_seq", 32'(seq_err), 0);
    ramp(4, 0); ramp(0, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
    check("kb11_count", 32'(cycle_count), 3);

    // Malformed pattern in UP_A
    ramp(0, 3);
    drive(1'b1, 16'h0005, 1'b0, 1'b1);
    check("therm_flag", 32'(therm_err), 1);
    check("therm_level", 32'(level), 3);
    check("therm_phase", 32'(phase), 7);
    feed(0);
    check("resync_idle", 32'(phase), 0);
    clear_flags();
    check("therm_clr", 32'(therm_err), 0);

    // Step error 0x0003 -> 0x000F
    ramp(0, 2);
    drive(1'b1, 16'h000F, 1'b0, 1'b1);
    check("step_flag", 32'(step_err), 1);
    check("step_phase", 32'(phase), 7);
    feed(0); clear_flags();

    // Sequence error: down at L=4 in UP_A
    ramp(0, 4); feed(3);
    check("seq_flag", 32'(seq_err), 1);
    check("seq_phase", 32'(phase), 7);
    feed(0); clear_flags();

    // Nominal with holds and invalid cycles interleaved
    gate = 1; kick_n = 0;
    nominal();
    gate = 0;
    check("gate_count", 32'(cycle_count), 4);
    check("gate_flags", 32'({therm_err, step_err, seq_err}), 0);
    check("gate_kicks", 32'(kick_n), 0);

    // Reset in the middle of UP_C
    ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 5); ramp(5, 9);
    check("upc_phase", 32'(phase), 5);
    drive(1'b1, pat(10), 1'b0, 1'b0);
    check("mid_rst", 32'({level, phase, cycle_count, kickback, cycle_done,
                          therm_err, step_err, seq_err}), 0);

    // Saturation of the narrow counter
    repeat (5) nominal();
    check("sat_wide", 32'(cycle_count), 5);
    check("sat_narrow", 32'(cycle_count_2), 3);

    // Random walk with occasional errors, gaps, clears and resets
    dir = 1;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      clr = ($urandom_range(0, 19) == 0);
      if (r < 2)       drive(1'b1, pat(m_level), clr, 1'b0);
      else if (r < 6)  drive(1'b1, 16'($urandom), clr, 1'b1);
      else if (r < 12) drive(1'b0, 16'($urandom), clr, 1'b1);
      else if (r < 15) drive(1'b1, pat($urandom_range(0, 16)), clr, 1'b1);
      else begin
        if (m_level >= 16) dir = -1;
        else if (m_level == 0) dir = 1;
        else if ($urandom_range(0, 9) == 0) dir = -dir;
        nxt = ($urandom_range(0, 7) == 0) ? m_level : m_level + dir;
        drive(1'b1, pat(nxt), clr, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
